// File: rtl/sync_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// sync_fifo_ctrl
//   Single-clock FIFO with a registered fill count, programmable almost-full /
//   almost-empty thresholds, standard-read or first-word-fall-through output,
//   sticky overflow/underflow flags and a synchronous flush.
//
// Parameters
//   ASIZE      address width, DEPTH = 2**ASIZE entries
//   DSIZE      data width
//   FWFT       0: out_data is loaded one cycle after a pop, out_valid pulses
//              1: out_data shows the head word whenever the FIFO is not empty
//   AFULL_LVL  out_almost_full  when count >= AFULL_LVL  (1..DEPTH)
//   AEMPTY_LVL out_almost_empty when count <= AEMPTY_LVL (0..DEPTH-1)
//
// Ports
//   clk               clock, all state changes on the rising edge
//   in_resetn         asynchronous active-low reset
//   in_data           write data
//   in_wr_en          push request
//   in_rd_en          pop request
//   in_clr            synchronous flush (dominates push/pop)
//   out_data          read data
//   out_valid         out_data holds a popped word (FWFT=0) / head word (FWFT=1)
//   out_full          count == DEPTH
//   out_empty         count == 0
//   out_almost_full   count >= AFULL_LVL
//   out_almost_empty  count <= AEMPTY_LVL
//   out_count         fill level 0..DEPTH
//   out_overflow      sticky: push attempted while full
//   out_underflow     sticky: pop attempted while empty
// ----------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int ASIZE      = 3,
  parameter int DSIZE      = 8,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = 7,
  parameter int AEMPTY_LVL = 1
) (
  input  logic             clk,
  input  logic             in_resetn,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_wr_en,
  input  logic             in_rd_en,
  input  logic             in_clr,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  output logic             out_full,
  output logic             out_empty,
  output logic             out_almost_full,
  output logic             out_almost_empty,
  output logic [ASIZE:0]   out_count,
  output logic             out_overflow,
  output logic             out_underflow
);

  localparam int             DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] C_DEPTH  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] C_AFULL  = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] C_AEMPTY = (ASIZE+1)'(AEMPTY_LVL);

  logic [DSIZE-1:0] r_mem [DEPTH];

  logic [ASIZE:0] r_wptr;
  logic [ASIZE:0] r_rptr;
  logic [ASIZE:0] r_count;
  logic           r_overflow;
  logic           r_underflow;

  logic           w_full;
  logic           w_empty;
  logic           w_push_ok;
  logic           w_pop_ok;
  logic [ASIZE:0] w_count_next;

  // Status is decoded purely from the registered count, so no request input
  // reaches any flag combinationally.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // Acceptance uses the registered flags: a pop in the same cycle does not
  // make room for a push while full, and a push does not feed a pop while
  // empty.
  assign w_push_ok = in_wr_en & ~w_full;
  assign w_pop_ok  = in_rd_en & ~w_empty;

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge in_resetn) begin
    if (!in_resetn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (in_clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
      if (in_wr_en && w_full)  r_overflow  <= 1'b1;
      if (in_rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push_ok && !in_clr) begin
      r_mem[r_wptr[ASIZE-1:0]] <= in_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented straight from the array; zero while empty so
      // the output matches its reset value after a reset or flush.
      assign out_data  = w_empty ? '0 : r_mem[r_rptr[ASIZE-1:0]];
      assign out_valid = ~w_empty;
    end else begin : g_std
      logic [DSIZE-1:0] r_rdata;
      logic             r_rvalid;

      always_ff @(posedge clk or negedge in_resetn) begin
        if (!in_resetn) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else if (in_clr) begin
          // Flush drops the valid pulse but leaves the last popped word.
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_pop_ok;
          if (w_pop_ok) r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
        end
      end

      assign out_data  = r_rdata;
      assign out_valid = r_rvalid;
    end
  endgenerate

  assign out_full         = w_full;
  assign out_empty        = w_empty;
  assign out_almost_full  = (r_count >= C_AFULL);
  assign out_almost_empty = (r_count <= C_AEMPTY);
  assign out_count        = r_count;
  assign out_overflow     = r_overflow;
  assign out_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
//   Drives one stimulus stream into two FIFO instances (standard read and
//   FWFT) and checks both against a queue-based reference model. Popped words
//   expected from the standard-read instance go into a scoreboard queue that a
//   separate monitor drains whenever out_valid is seen.
// ----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] din = '0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] s_data;
  logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [3:0] s_count;
  logic [7:0] f_data;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] f_count;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.ASIZE(3), .DSIZE(8), .FWFT(0), .AFULL_LVL(7), .AEMPTY_LVL(1)) dut_std (
    .clk(clk), .in_resetn(rstn), .in_data(din), .in_wr_en(wr), .in_rd_en(rd), .in_clr(clr),
    .out_data(s_data), .out_valid(s_valid), .out_full(s_full), .out_empty(s_empty),
    .out_almost_full(s_af), .out_almost_empty(s_ae), .out_count(s_count),
    .out_overflow(s_ovf), .out_underflow(s_unf)
  );

  sync_fifo_ctrl #(.ASIZE(3), .DSIZE(8), .FWFT(1), .AFULL_LVL(7), .AEMPTY_LVL(1)) dut_fwft (
    .clk(clk), .in_resetn(rstn), .in_data(din), .in_wr_en(wr), .in_rd_en(rd), .in_clr(clr),
    .out_data(f_data), .out_valid(f_valid), .out_full(f_full), .out_empty(f_empty),
    .out_almost_full(f_af), .out_almost_empty(f_ae), .out_count(f_count),
    .out_overflow(f_ovf), .out_underflow(f_unf)
  );

  // Reference model state
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         m_ovf, m_unf, m_valid;
  logic [7:0] m_last;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: applies the accept/count/error rules to the inputs seen at each
  // rising edge, using the pre-edge state.
  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        model_q.delete();
        exp_q.delete();
        m_ovf = 0; m_unf = 0; m_valid = 0; m_last = '0;
      end else if (clr) begin
        model_q.delete();
        m_ovf = 0; m_unf = 0; m_valid = 0;
      end else begin
        automatic int  cnt  = model_q.size();
        automatic bit  full = (cnt == DEPTH);
        automatic bit  emp  = (cnt == 0);
        if (wr && full) m_ovf = 1;
        if (rd && emp)  m_unf = 1;
        m_valid = 0;
        if (rd && !emp) begin
          exp_q.push_back(model_q.pop_front());
          m_valid = 1;
        end
        if (wr && !full) model_q.push_back(din);
      end
    end
  end

  // Monitor: compares both instances against the model away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        automatic int cnt = model_q.size();
        check("count",        32'(s_count), 32'(cnt));
        check("full",         32'(s_full),  32'(cnt == DEPTH));
        check("empty",        32'(s_empty), 32'(cnt == 0));
        check("almost_full",  32'(s_af),    32'(cnt >= 7));
        check("almost_empty", 32'(s_ae),    32'(cnt <= 1));
        check("overflow",     32'(s_ovf),   32'(m_ovf));
        check("underflow",    32'(s_unf),   32'(m_unf));
        check("fwft_status",  {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_unf},
                              {s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf});
        check("std_valid",    32'(s_valid), 32'(m_valid));
        if (s_valid) begin
          if (exp_q.size() == 0) begin
            check("std_unexpected_valid", 32'(s_valid), 32'd0);
          end else begin
            m_last = exp_q.pop_front();
            n_pops++;
            check("std_data", 32'(s_data), 32'(m_last));
          end
        end else begin
          check("std_data_hold", 32'(s_data), 32'(m_last));
        end
        check("fwft_valid", 32'(f_valid), 32'(cnt != 0));
        check("fwft_data",  32'(f_data),  (cnt != 0) ? 32'(model_q[0]) : 32'd0);
      end
    end
  end

  task automatic step(bit w, bit r, bit c, logic [7:0] d);
    @(negedge clk);
    wr = w; rd = r; clr = c; din = d;
    $display("cycle t=%0t wr=%0b rd=%0b clr=%0b din=0x%02h count=%0d", $time, w, r, c, d, s_count);
  endtask

  initial begin
    #12 rstn = 1'b1;
    // Reset values before any edge with reset released
    check("rst_count", 32'(s_count), 32'd0);
    check("rst_empty", 32'(s_empty), 32'd1);
    check("rst_ae",    32'(s_ae),    32'd1);

    // Fill with 0x10..0x17, one extra push to overflow
    for (int i = 0; i < 9; i++) step(1, 0, 0, 8'(8'h10 + i));
    // Drain all eight, one extra pop to underflow
    for (int i = 0; i < 9; i++) step(0, 1, 0, 8'h00);
    // Hold count at 4 with simultaneous push/pop so the pointers wrap
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) step(1, 1, 0, 8'(8'h50 + i));
    // Full with both sticky flags set, then flush with a push pending
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h60 + i));
    step(1, 0, 0, 8'hEE);
    step(1, 1, 1, 8'hDD);
    step(0, 0, 0, 8'h00);
    // FWFT single word into empty, then pop it
    step(1, 0, 0, 8'hA5);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 2), 8'($urandom));
    end

    // Asynchronous reset at count 5 with a pop in flight
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'(8'h70 + i));
    step(0, 1, 0, 8'h00);
    @(posedge clk);
    #2 rstn = 1'b0;
    wr = 0; rd = 0; clr = 0;
    #1;
    check("arst_count",  32'(s_count), 32'd0);
    check("arst_flags",  {s_full, s_empty, s_af, s_ae, s_ovf, s_unf}, 32'b010100);
    check("arst_std",    {s_valid, s_data}, 32'd0);
    check("arst_fwft",   {f_valid, f_data, f_count}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 50), 1'b0, 8'($urandom));
    end
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("pops_seen_nonzero", 32'(n_pops > 8), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
